// File: rtl/eth_tx_pkg.sv
// Shared types for the Ethernet TX path.
//   state_t        : frame reader FSM states
//   byte_idx_t     : byte position inside a 32-bit word
//   BYTES_PER_WORD : bytes per FIFO word
//   word_byte()    : big-endian byte select (idx 0 -> bits 31:24)
package eth_tx_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, GAP} state_t;
  typedef logic [1:0] byte_idx_t;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input byte_idx_t idx);
    case (idx)
      2'd0:    word_byte = word[31:24];
      2'd1:    word_byte = word[23:16];
      2'd2:    word_byte = word[15:8];
      default: word_byte = word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ifg_counter.sv
// Loadable down-counter timing the inter-frame gap.
//   clk, rst : clock, synchronous active-high reset
//   load     : load load_val (takes priority over dec)
//   load_val : start value
//   dec      : count down by one, saturating at zero
//   done     : count is zero
module ifg_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains 32-bit words from the TX FIFO and emits them as a big-endian byte
// stream with sop/eop markers. A frame starts only once a whole frame is
// buffered, and a fixed idle gap follows every frame.
//   clk, rst         : clock, synchronous active-high reset
//   fifo_empty/usedw : FIFO status (usedw only looked at in IDLE)
//   fifo_q           : FIFO data, valid the cycle after fifo_rdreq
//   fifo_rdreq       : one pulse per word, only in FETCH and never when empty
//   tx_*             : byte stream, valid/ready handshake
//   busy             : not in IDLE
//   frame_count      : completed frames, wraps
//   underrun         : FIFO empty while in FETCH
module fifo_frame_reader
  import eth_tx_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 8,
  parameter int USEDW_W         = 9,
  parameter int IFG_CYCLES      = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic [31:0]        fifo_q,
  output logic               fifo_rdreq,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_sop,
  output logic               tx_eop,
  output logic               busy,
  output logic [15:0]        frame_count,
  output logic               underrun
);

  localparam logic [31:0] START_LVL = 32'(WORDS_PER_FRAME);
  localparam logic [7:0]  LAST_WORD = 8'(WORDS_PER_FRAME - 1);
  // Counter is loaded on the SEND->GAP edge, so GAP lasts IFG_CYCLES clocks.
  localparam logic [7:0]  IFG_LOAD  = 8'(IFG_CYCLES - 1);
  localparam byte_idx_t   LAST_BYTE = byte_idx_t'(BYTES_PER_WORD - 1);

  state_t      state_q, state_d;
  byte_idx_t   idx_q, idx_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [31:0] word_q, word_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic accept, last_byte, last_word, ifg_load, ifg_done;

  assign accept    = tx_valid && tx_ready;
  assign last_byte = (idx_q == LAST_BYTE);
  assign last_word = (word_cnt_q == LAST_WORD);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    word_cnt_d    = word_cnt_q;
    word_d        = word_q;
    frame_count_d = frame_count_q;
    ifg_load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (32'(fifo_usedw) >= START_LVL) begin
          state_d    = FETCH;
          word_cnt_d = '0;
        end
      end
      FETCH: begin
        // Read request goes out this cycle; hold here while the FIFO is empty.
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        word_d  = fifo_q;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (accept) begin
          idx_d = idx_q + 2'd1;
          if (last_byte) begin
            if (last_word) begin
              state_d       = GAP;
              ifg_load      = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
            end else begin
              word_cnt_d = word_cnt_q + 8'd1;
              state_d    = FETCH;
            end
          end
        end
      end
      GAP: begin
        if (ifg_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      word_cnt_q    <= '0;
      word_q        <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      word_cnt_q    <= word_cnt_d;
      word_q        <= word_d;
      frame_count_q <= frame_count_d;
    end
  end

  ifg_counter #(.CNT_W(8)) u_ifg (
    .clk      (clk),
    .rst      (rst),
    .load     (ifg_load),
    .load_val (IFG_LOAD),
    .dec      (state_q == GAP),
    .done     (ifg_done)
  );

  // Stream outputs decode only flopped state, so they hold still under
  // backpressure without extra registers.
  assign tx_valid    = (state_q == SEND);
  assign tx_data     = word_byte(word_q, idx_q);
  assign tx_sop      = tx_valid && (word_cnt_q == '0) && (idx_q == '0);
  assign tx_eop      = tx_valid && last_word && last_byte;
  assign fifo_rdreq  = (state_q == FETCH) && !fifo_empty;
  assign underrun    = (state_q == FETCH) && fifo_empty;
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Self-checking bench for fifo_frame_reader: FIFO model, byte-stream
// reference built from the queued words, scenario table plus corner cases.
module tb_fifo_frame_reader;

  localparam int WPF = 8;
  localparam int UW  = 9;
  localparam int IFG = 12;

  logic          clk = 1'b0, rst = 1'b1;
  logic          fifo_empty, fifo_rdreq;
  logic [UW-1:0] fifo_usedw;
  logic [31:0]   fifo_q = '0;
  logic          tx_ready = 1'b1, tx_valid, tx_sop, tx_eop, busy, underrun;
  logic [7:0]    tx_data;
  logic [15:0]   frame_count;

  // FIFO model controls
  logic          force_empty = 1'b0, force_en = 1'b0, op_go = 1'b0;
  logic [UW-1:0] force_val = '0;
  logic [31:0]   mem[$];
  logic [31:0]   op_vals[$];
  int            lvl = 0;

  // reference / scoreboard
  logic [31:0]   mdl[$];
  logic [9:0]    got[$];
  logic [9:0]    exp_q[$];
  int            gp = 0, nvec = 0, nerr = 0;

  // monitor counters (written only by the monitor)
  int            rd_cnt = 0, rd_bad = 0, stab_err = 0, vld_cyc = 0;
  logic          pw = 1'b0, prst = 1'b0;
  logic [9:0]    pv = '0;

  always #5 clk = ~clk;

  assign fifo_empty = force_empty || (lvl == 0);
  assign fifo_usedw = force_en ? force_val : UW'(lvl);

  fifo_frame_reader #(.WORDS_PER_FRAME(WPF), .USEDW_W(UW), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw),
    .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .busy(busy), .frame_count(frame_count), .underrun(underrun)
  );

  // Non-show-ahead FIFO: data appears the cycle after the read request.
  always @(posedge clk) begin
    if (fifo_rdreq && !fifo_empty && mem.size() > 0) fifo_q <= mem.pop_front();
    if (op_go) foreach (op_vals[i]) mem.push_back(op_vals[i]);
    lvl <= mem.size();
  end

  always @(negedge clk) begin
    if (tx_valid) vld_cyc <= vld_cyc + 1;
    if (tx_valid && tx_ready) got.push_back({tx_sop, tx_eop, tx_data});
    if (fifo_rdreq) rd_cnt <= rd_cnt + 1;
    if (fifo_rdreq && fifo_empty) rd_bad <= rd_bad + 1;
    if (pw && !prst && (!tx_valid || {tx_sop, tx_eop, tx_data} != pv)) stab_err <= stab_err + 1;
    pw   <= tx_valid && !tx_ready;
    prst <= rst;
    pv   <= {tx_sop, tx_eop, tx_data};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tx_ready = 1'b1; force_empty = 1'b0; force_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
    gp = got.size();
  endtask

  task automatic fill(input int base, input int n, input bit rnd);
    logic [31:0] w;
    op_vals.delete();
    for (int i = 0; i < n; i++) begin
      w = rnd ? $urandom : 32'(base + i);
      op_vals.push_back(w);
      mdl.push_back(w);
    end
    op_go = 1'b1;
    tick();
    op_go = 1'b0;
  endtask

  // A frame is the next WPF queued words, each sent most-significant byte first.
  task automatic expect_frame();
    logic [31:0] w;
    for (int k = 0; k < WPF; k++) begin
      w = (mdl.size() > 0) ? mdl.pop_front() : 32'hDEAD_BEEF;
      for (int b = 0; b < 4; b++)
        exp_q.push_back({k == 0 && b == 0, k == WPF - 1 && b == 3, w[31 - 8*b -: 8]});
    end
  endtask

  // mode 0: always ready; 1: alternate starting with a stall on the first byte;
  // 2: random ready
  task automatic stream(input int mode, input string name);
    int n = exp_q.size();
    int t = 0;
    bit started = 1'b0;
    while (got.size() < gp + n && t < 4000) begin
      case (mode)
        0: tx_ready = 1'b1;
        1: begin
          if (!started) begin
            tx_ready = 1'b0;
            if (tx_valid) started = 1'b1;
          end else tx_ready = ~tx_ready;
        end
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
      tick();
      t++;
    end
    tx_ready = 1'b1;
    chk({name, " complete"}, 32'(got.size() >= gp + n), 32'd1);
    for (int i = 0; i < n; i++)
      if (gp + i < got.size()) chk($sformatf("%s byte%0d", name, i), 32'(got[gp + i]), 32'(exp_q[i]));
    gp += n;
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 200) begin tick(); t++; end
    chk(name, 32'(busy), 32'd0);
  endtask

  typedef struct {
    int mode;
    int nwords;
    bit rnd;
    int exp_frames;
    int exp_vld;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   b_rd, b_stab, b_vld, b_bad, bad, dropped, t;
    int   first_vld, eop_c, gap, idle, ph;

    tbl[0] = '{mode: 0, nwords: 8,  rnd: 1'b0, exp_frames: 1, exp_vld: 32};
    tbl[1] = '{mode: 1, nwords: 8,  rnd: 1'b0, exp_frames: 1, exp_vld: 64};
    tbl[2] = '{mode: 0, nwords: 16, rnd: 1'b0, exp_frames: 2, exp_vld: 64};
    tbl[3] = '{mode: 2, nwords: 24, rnd: 1'b1, exp_frames: 3, exp_vld: -1};

    // reset state
    tick(); tick();
    chk("rst tx_valid",    32'(tx_valid),    0);
    chk("rst sop/eop",     32'({tx_sop, tx_eop}), 0);
    chk("rst tx_data",     32'(tx_data),     0);
    chk("rst busy",        32'(busy),        0);
    chk("rst frame_count", 32'(frame_count), 0);
    chk("rst rdreq/undr",  32'({fifo_rdreq, underrun}), 0);
    rst = 1'b0;

    // scenario table
    for (int r = 0; r < 4; r++) begin
      do_reset();
      b_rd = rd_cnt; b_stab = stab_err; b_vld = vld_cyc; b_bad = rd_bad;
      fill(1, tbl[r].nwords, tbl[r].rnd);
      for (int f = 0; f < tbl[r].exp_frames; f++) expect_frame();
      stream(tbl[r].mode, $sformatf("row%0d", r));
      wait_idle($sformatf("row%0d idle", r));
      chk($sformatf("row%0d frame_count", r), 32'(frame_count), 32'(tbl[r].exp_frames));
      chk($sformatf("row%0d rdreq pulses", r), 32'(rd_cnt - b_rd), 32'(tbl[r].nwords));
      chk($sformatf("row%0d held under stall", r), 32'(stab_err - b_stab), 0);
      chk($sformatf("row%0d rdreq when empty", r), 32'(rd_bad - b_bad), 0);
      if (tbl[r].exp_vld >= 0)
        chk($sformatf("row%0d valid cycles", r), 32'(vld_cyc - b_vld), 32'(tbl[r].exp_vld));
    end

    // frame timing and inter-frame gap, two frames back to back
    do_reset();
    b_rd = rd_cnt;
    fill(1, 16, 1'b0);
    expect_frame(); expect_frame();
    t = 0;
    while (!busy && t < 50) begin tick(); t++; end
    chk("b2b fetch entry", 32'(busy), 1);
    first_vld = -1; eop_c = -1; gap = 0; idle = 0; ph = 0;
    for (int c = 0; c < 300 && ph < 3; c++) begin
      if (tx_valid && first_vld < 0) first_vld = c;
      case (ph)
        0: if (tx_valid && tx_eop) begin eop_c = c; ph = 1; end
        1: if (busy) gap++; else begin idle = 1; ph = 2; end
        default: if (!busy) idle++; else ph = 3;
      endcase
      if (ph < 3) tick();
    end
    chk("first byte latency", 32'(first_vld), 2);
    chk("frame clocks to eop", 32'(eop_c + 1), 48);
    chk("gap clocks", 32'(gap), 32'(IFG));
    chk("idle clocks", 32'(idle), 1);
    stream(0, "b2b");
    wait_idle("b2b idle");
    chk("b2b frame_count", 32'(frame_count), 2);
    chk("b2b rdreq pulses", 32'(rd_cnt - b_rd), 16);

    // start threshold
    do_reset();
    force_en = 1'b1; force_val = UW'(WPF - 1);
    fill(1, 8, 1'b0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy || fifo_rdreq) bad++;
    end
    chk("below threshold idle", 32'(bad), 0);
    force_val = UW'(WPF);
    tick();
    chk("threshold fetch busy", 32'(busy), 1);
    chk("threshold fetch rdreq", 32'(fifo_rdreq), 1);
    force_en = 1'b0;
    expect_frame();
    stream(0, "thresh");
    wait_idle("thresh idle");

    // reset after the 10th byte
    do_reset();
    b_rd = rd_cnt;
    fill(1, 8, 1'b0);
    t = 0;
    while (got.size() < gp + 10 && t < 500) begin tick(); t++; end
    chk("10 bytes before reset", 32'(got.size() >= gp + 10), 1);
    rst = 1'b1; tx_ready = 1'b0;
    tick();
    chk("midrst tx_valid", 32'(tx_valid), 0);
    chk("midrst frame_count", 32'(frame_count), 0);
    chk("midrst busy", 32'(busy), 0);
    rst = 1'b0; tx_ready = 1'b1;
    dropped = rd_cnt - b_rd;
    chk("midrst words popped", 32'(dropped), 3);
    for (int i = 0; i < dropped && mdl.size() > 0; i++) void'(mdl.pop_front());
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || fifo_rdreq) bad++;
    end
    chk("midrst waits for 8 words", 32'(bad), 0);
    gp = got.size();
    fill(9, 3, 1'b0);
    expect_frame();
    stream(0, "midrst resume");
    wait_idle("midrst idle");
    chk("midrst resume count", 32'(frame_count), 1);

    // FIFO reports empty while in FETCH
    do_reset();
    force_empty = 1'b1; force_en = 1'b1; force_val = UW'(WPF);
    fill(1, 8, 1'b0);
    t = 0;
    while (!busy && t < 50) begin tick(); t++; end
    chk("empty fetch entry", 32'(busy), 1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (!underrun || fifo_rdreq || tx_valid || !busy) bad++;
      tick();
    end
    chk("underrun held", 32'(bad), 0);
    force_empty = 1'b0; force_en = 1'b0;
    expect_frame();
    stream(0, "empty resume");
    wait_idle("empty idle");
    chk("empty frame_count", 32'(frame_count), 1);
    chk("rdreq never when empty", 32'(rd_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
